// File: rtl/fpnew_result_checker.sv
// In-order response scoreboard for an FPnew output port: expected results are queued with
// their tags, each FPU result retires the queue head, and pass/error statistics are exposed.
module fpnew_result_checker #(
   parameter int WIDTH     = 32,
   parameter int TAG_W     = 1,
   parameter int DEPTH     = 4,
   parameter int CNT_W     = 16,
   parameter bit NAN_LOOSE = 1'b1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clear_i,
   input  logic             exp_valid_i,
   output logic             exp_ready_o,
   input  logic [WIDTH-1:0] exp_data_i,
   input  logic [TAG_W-1:0] exp_tag_i,
   input  logic             res_valid_i,
   output logic             res_ready_o,
   input  logic [WIDTH-1:0] res_data_i,
   input  logic [TAG_W-1:0] res_tag_i,
   output logic             err_valid_o,
   output logic [WIDTH-1:0] err_exp_o,
   output logic [WIDTH-1:0] err_got_o,
   output logic [WIDTH-1:0] first_err_o,
   output logic [CNT_W-1:0] pass_cnt_o,
   output logic [CNT_W-1:0] err_cnt_o,
   output logic             underflow_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]       wr_ptr_r;
   logic [AW:0]       rd_ptr_r;
   logic [WIDTH-1:0]  mem_data_r [DEPTH];
   logic [TAG_W-1:0]  mem_tag_r  [DEPTH];
   logic              err_valid_r;
   logic [WIDTH-1:0]  err_exp_r;
   logic [WIDTH-1:0]  err_got_r;
   logic [WIDTH-1:0]  first_err_r;
   logic [CNT_W-1:0]  pass_cnt_r;
   logic [CNT_W-1:0]  err_cnt_r;
   logic              underflow_r;

   logic              full_s;
   logic              empty_s;
   logic              push_s;
   logic              pop_s;
   logic [WIDTH-1:0]  head_data_s;
   logic [TAG_W-1:0]  head_tag_s;
   logic              match_s;
   logic [CNT_W-1:0]  pass_next_s;
   logic [CNT_W-1:0]  err_next_s;

   // NaN/Inf class test on the single-precision exponent field position.
   function automatic logic exp_all_ones(input logic [WIDTH-1:0] value);
      return &value[WIDTH-2:WIDTH-9];
   endfunction

   // Queue status, handshakes, head compare and saturating counter increments.
   always_comb begin
      full_s      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
      empty_s     = (wr_ptr_r == rd_ptr_r);
      push_s      = exp_valid_i && !full_s;
      pop_s       = res_valid_i && !empty_s;
      head_data_s = mem_data_r[rd_ptr_r[AW-1:0]];
      head_tag_s  = mem_tag_r[rd_ptr_r[AW-1:0]];
      match_s     = ((head_data_s == res_data_i) ||
                     (NAN_LOOSE && exp_all_ones(head_data_s) && exp_all_ones(res_data_i))) &&
                    (head_tag_s == res_tag_i);
      if (pass_cnt_r == {CNT_W{1'b1}}) begin
         pass_next_s = pass_cnt_r;
      end else begin
         pass_next_s = pass_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (err_cnt_r == {CNT_W{1'b1}}) begin
         err_next_s = err_cnt_r;
      end else begin
         err_next_s = err_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   // Entry storage; contents are only meaningful between the pointers, so clear leaves it.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_data_r[i] <= {WIDTH{1'b0}};
            mem_tag_r[i]  <= {TAG_W{1'b0}};
         end
      end else if (push_s && !clear_i) begin
         mem_data_r[wr_ptr_r[AW-1:0]] <= exp_data_i;
         mem_tag_r[wr_ptr_r[AW-1:0]]  <= exp_tag_i;
      end
   end

   // Pointers, statistics and mismatch reporting; clear discards same-cycle traffic.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_r    <= {(AW+1){1'b0}};
         rd_ptr_r    <= {(AW+1){1'b0}};
         err_valid_r <= 1'b0;
         err_exp_r   <= {WIDTH{1'b0}};
         err_got_r   <= {WIDTH{1'b0}};
         first_err_r <= {WIDTH{1'b0}};
         pass_cnt_r  <= {CNT_W{1'b0}};
         err_cnt_r   <= {CNT_W{1'b0}};
         underflow_r <= 1'b0;
      end else if (clear_i) begin
         wr_ptr_r    <= {(AW+1){1'b0}};
         rd_ptr_r    <= {(AW+1){1'b0}};
         err_valid_r <= 1'b0;
         err_exp_r   <= {WIDTH{1'b0}};
         err_got_r   <= {WIDTH{1'b0}};
         first_err_r <= {WIDTH{1'b0}};
         pass_cnt_r  <= {CNT_W{1'b0}};
         err_cnt_r   <= {CNT_W{1'b0}};
         underflow_r <= 1'b0;
      end else begin
         err_valid_r <= 1'b0;
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
         end
         if (res_valid_i) begin
            if (!empty_s && match_s) begin
               pass_cnt_r <= pass_next_s;
            end else begin
               // Mismatch or underflow: an underflow reports zero as the expected value.
               err_cnt_r   <= err_next_s;
               err_valid_r <= 1'b1;
               err_exp_r   <= empty_s ? {WIDTH{1'b0}} : head_data_s;
               err_got_r   <= res_data_i;
               if (err_cnt_r == {CNT_W{1'b0}}) begin
                  first_err_r <= res_data_i;
               end
               if (empty_s) begin
                  underflow_r <= 1'b1;
               end
            end
         end
      end
   end

   assign exp_ready_o = !full_s;
   assign empty_o     = empty_s;
   assign res_ready_o = 1'b1;
   assign err_valid_o = err_valid_r;
   assign err_exp_o   = err_exp_r;
   assign err_got_o   = err_got_r;
   assign first_err_o = first_err_r;
   assign pass_cnt_o  = pass_cnt_r;
   assign err_cnt_o   = err_cnt_r;
   assign underflow_o = underflow_r;

endmodule
